// File: rtl/triloc_pkg.sv
// Shared definitions for the TriLoc host-side frame assembler: party codes, FSM states,
// frame/result widths and the bit offset of every field in the packed evaluator frame.
package triloc_pkg;

  typedef enum logic [1:0] {
    PARTY_A = 2'd0,
    PARTY_B = 2'd1,
    PARTY_C = 2'd2,
    PARTY_Q = 2'd3
  } party_e;

  typedef enum logic [1:0] {
    S_COLLECT  = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_RES = 2'd2,
    S_DELIVER  = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_N   = 8;
  localparam int unsigned NUM_PARTIES = 4;
  localparam int unsigned NUM_COORDS  = 6;
  localparam int unsigned NUM_RADII   = 3;

  function automatic int frame_w(input int n);
    return 9 * n + 3;
  endfunction

  function automatic int beat_w(input int n);
    return 3 * n + 3;
  endfunction

  function automatic int result_w(input int n);
    return 2 * n + 8;
  endfunction

  function automatic int res_field_w(input int n);
    return n + 4;
  endfunction

  // Coordinate k in order xA,yA,xB,yB,xC,yC; xA sits at the top of the frame.
  function automatic int coord_lsb(input int n, input int k);
    return (8 - k) * n + 3;
  endfunction

  // Radius j in order rA,rB,rC; rC sits at bit 0.
  function automatic int radius_lsb(input int n, input int j);
    return (2 - j) * (n + 1);
  endfunction

  localparam int unsigned FRAME_W  = 9 * DEFAULT_N + 3;
  localparam int unsigned RESULT_W = 2 * DEFAULT_N + 8;

endpackage

// File: rtl/triloc_field_pack.sv
// Pure bit placement of the six anchor coordinates and three radii into the evaluator frame.
// Inputs are MSB-first concatenations: coords={xA,yA,xB,yB,xC,yC}, radii={rA,rB,rC}.
module triloc_field_pack
  import triloc_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [6*N-1:0] coords,
  input  logic [3*N+2:0] radii,
  output logic [9*N+2:0] frame
);

  for (genvar k = 0; k < 6; k++) begin : g_coord
    localparam int LSB = coord_lsb(N, k);
    assign frame[LSB +: N] = coords[(5 - k) * N +: N];
  end

  for (genvar j = 0; j < 3; j++) begin : g_radius
    localparam int LSB = radius_lsb(N, j);
    assign frame[LSB +: N+1] = radii[(2 - j) * (N + 1) +: N+1];
  end

endmodule

// File: rtl/triloc_frame_assembler.sv
// Collects A/B/C anchor and Q radius beats in any order, issues the packed frame to the
// evaluator with valid/ready, then captures and delivers the signed xM/yM result.
module triloc_frame_assembler
  import triloc_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_party,
  input  logic [3*N+2:0] in_data,
  output logic [9*N+2:0] p_input,
  output logic           p_valid,
  input  logic           p_ready,
  input  logic [2*N+7:0] o,
  input  logic           o_valid,
  output logic [N+3:0]   xM,
  output logic [N+3:0]   yM,
  output logic           res_valid,
  input  logic           res_ready,
  output logic           dup_err,
  output logic           timeout_err
);

  localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned T_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  state_e             state;
  logic [3:0]         got;
  logic [6*N-1:0]     coords_q;
  logic [3*N+2:0]     radii_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic               accept;
  logic [3:0]         got_next;

  // Ready is gated by reset so no beat is ever taken while reset is held.
  assign in_ready = (state == S_COLLECT) && !rst;
  assign accept   = in_valid && in_ready;
  assign got_next = got | (4'b0001 << in_party);

  triloc_field_pack #(.N(N)) u_pack (
    .coords (coords_q),
    .radii  (radii_q),
    .frame  (p_input)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_COLLECT;
      got         <= '0;
      coords_q    <= '0;
      radii_q     <= '0;
      wait_cnt    <= '0;
      p_valid     <= 1'b0;
      xM          <= '0;
      yM          <= '0;
      res_valid   <= 1'b0;
      dup_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      dup_err     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_COLLECT: begin
          if (accept) begin
            if (got[in_party]) begin
              dup_err <= 1'b1;
            end else begin
              got <= got_next;
              case (party_e'(in_party))
                PARTY_A: coords_q[4*N +: 2*N] <= in_data[2*N-1:0];
                PARTY_B: coords_q[2*N +: 2*N] <= in_data[2*N-1:0];
                PARTY_C: coords_q[0   +: 2*N] <= in_data[2*N-1:0];
                default: radii_q              <= in_data;
              endcase
              if (got_next == 4'b1111) begin
                state   <= S_ISSUE;
                p_valid <= 1'b1;
              end
            end
          end
        end
        S_ISSUE: begin
          if (p_ready) begin
            p_valid  <= 1'b0;
            wait_cnt <= '0;
            state    <= S_WAIT_RES;
          end
        end
        S_WAIT_RES: begin
          // A result arriving on the last allowed cycle still wins over the abort.
          if (o_valid) begin
            xM        <= o[2*N+7:N+4];
            yM        <= o[N+3:0];
            res_valid <= 1'b1;
            state     <= S_DELIVER;
          end else if (TIMEOUT != 0 && wait_cnt == CNT_W'(T_LAST)) begin
            timeout_err <= 1'b1;
            got         <= '0;
            coords_q    <= '0;
            radii_q     <= '0;
            state       <= S_COLLECT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DELIVER: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            got       <= '0;
            coords_q  <= '0;
            radii_q   <= '0;
            state     <= S_COLLECT;
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_triloc_frame_assembler.sv
// Directed bench for triloc_frame_assembler (N=8, TIMEOUT=16) with hand-computed expectations.
module tb_triloc_frame_assembler;

  localparam int unsigned N  = 8;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_party;
  logic [26:0]   in_data;
  logic [74:0]   p_input;
  logic          p_valid;
  logic          p_ready;
  logic [23:0]   o;
  logic          o_valid;
  logic [11:0]   xM;
  logic [11:0]   yM;
  logic          res_valid;
  logic          res_ready;
  logic          dup_err;
  logic          timeout_err;

  logic [47:0]   ref_coords;
  logic [26:0]   ref_radii;
  logic [74:0]   ref_frame;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  triloc_frame_assembler #(.N(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_party    (in_party),
    .in_data     (in_data),
    .p_input     (p_input),
    .p_valid     (p_valid),
    .p_ready     (p_ready),
    .o           (o),
    .o_valid     (o_valid),
    .xM          (xM),
    .yM          (yM),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .dup_err     (dup_err),
    .timeout_err (timeout_err)
  );

  triloc_field_pack #(.N(N)) u_ref_pack (
    .coords (ref_coords),
    .radii  (ref_radii),
    .frame  (ref_frame)
  );

  function automatic logic [74:0] exp_frame(
    input logic [7:0] xa, input logic [7:0] ya, input logic [7:0] xb, input logic [7:0] yb,
    input logic [7:0] xc, input logic [7:0] yc, input logic [8:0] ra, input logic [8:0] rb,
    input logic [8:0] rc);
    return {xa, ya, xb, yb, xc, yc, ra, rb, rc};
  endfunction

  function automatic logic [26:0] cbeat(input logic [7:0] x, input logic [7:0] y);
    return {11'h000, x, y};
  endfunction

  function automatic logic [26:0] rbeat(input logic [8:0] ra, input logic [8:0] rb,
                                        input logic [8:0] rc);
    return {ra, rb, rc};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] party, input logic [26:0] data);
    chk("in_ready_before_beat", in_ready, 1'b1);
    in_valid = 1'b1;
    in_party = party;
    in_data  = data;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic handshake_frame();
    p_ready = 1'b1;
    tick();
    p_ready = 1'b0;
    chk("p_valid_after_handshake", p_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    logic [74:0] f1, f2, f6;
    f1 = exp_frame(8'h05, 8'hFB, 8'h10, 8'hF0, 8'h80, 8'h7F, 9'h001, 9'h0FF, 9'h100);
    f2 = exp_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 9'h1AA, 9'h055, 9'h0F0);
    f6 = exp_frame(8'h7E, 8'h81, 8'h01, 8'hFF, 8'hC3, 8'h3C, 9'h0AB, 9'h1CD, 9'h0EF);

    rst = 1'b1; in_valid = 1'b0; in_party = 2'd0; in_data = '0;
    p_ready = 1'b0; o = '0; o_valid = 1'b0; res_ready = 1'b0;
    ref_coords = {8'h05, 8'hFB, 8'h10, 8'hF0, 8'h80, 8'h7F};
    ref_radii  = {9'h001, 9'h0FF, 9'h100};

    // Reset state
    tick(); tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_p_input", p_input, 75'h0);
    chk("rst_p_valid", p_valid, 1'b0);
    chk("rst_xM", xM, 12'h0);
    chk("rst_yM", yM, 12'h0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_dup_err", dup_err, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("ref_pack_layout", ref_frame, f1);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1'b1);

    // 1: in-order frame, then result capture and delivery
    beat(2'd0, cbeat(8'h05, 8'hFB));
    beat(2'd1, cbeat(8'h10, 8'hF0));
    beat(2'd2, cbeat(8'h80, 8'h7F));
    chk("t1_p_valid_before_q", p_valid, 1'b0);
    beat(2'd3, rbeat(9'h001, 9'h0FF, 9'h100));
    chk("t1_p_valid", p_valid, 1'b1);
    chk("t1_p_input", p_input, f1);
    chk("t1_in_ready_issue", in_ready, 1'b0);
    handshake_frame();
    chk("t1_in_ready_wait", in_ready, 1'b0);
    chk("t1_res_valid_wait", res_valid, 1'b0);

    // 4: result split and hold under back-pressure
    o = 24'h8007FF; o_valid = 1'b1;
    tick();
    o_valid = 1'b0;
    chk("t4_res_valid", res_valid, 1'b1);
    chk("t4_xM", xM, 12'h800);
    chk("t4_yM", yM, 12'h7FF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_res_valid_hold", res_valid, 1'b1);
      chk("t4_xM_hold", xM, 12'h800);
    end
    o = 24'h123456; o_valid = 1'b1;
    tick();
    o_valid = 1'b0;
    chk("t4_o_valid_ignored_x", xM, 12'h800);
    chk("t4_o_valid_ignored_y", yM, 12'h7FF);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t4_res_valid_done", res_valid, 1'b0);
    chk("t4_in_ready_collect", in_ready, 1'b1);
    chk("t4_p_input_cleared", p_input, 75'h0);
    chk("t4_xM_kept", xM, 12'h800);

    // 2: reverse order with evaluator back-pressure
    beat(2'd3, rbeat(9'h1AA, 9'h055, 9'h0F0));
    beat(2'd2, cbeat(8'h55, 8'h66));
    beat(2'd1, cbeat(8'h33, 8'h44));
    beat(2'd0, cbeat(8'h11, 8'h22));
    in_valid = 1'b1; in_party = 2'd0; in_data = cbeat(8'hEE, 8'hDD);
    for (int i = 0; i < 5; i++) begin
      chk("t2_p_valid_hold", p_valid, 1'b1);
      chk("t2_p_input_hold", p_input, f2);
      chk("t2_in_ready_low", in_ready, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    chk("t2_dup_err_quiet", dup_err, 1'b0);
    chk("t2_p_input_final", p_input, f2);
    handshake_frame();

    // 5a: timeout after 16 cycles without a result
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t5_no_timeout_yet", timeout_err, 1'b0);
      chk("t5_in_ready_wait", in_ready, 1'b0);
    end
    tick();
    chk("t5_timeout_err", timeout_err, 1'b1);
    chk("t5_in_ready_collect", in_ready, 1'b1);
    chk("t5_p_input_cleared", p_input, 75'h0);
    chk("t5_res_valid", res_valid, 1'b0);
    tick();
    chk("t5_timeout_pulse_end", timeout_err, 1'b0);

    // 3: duplicate A beat is dropped
    beat(2'd0, cbeat(8'h05, 8'hFB));
    chk("t3_no_dup_first", dup_err, 1'b0);
    beat(2'd0, cbeat(8'h05, 8'hAA));
    chk("t3_dup_err", dup_err, 1'b1);
    beat(2'd1, cbeat(8'h10, 8'hF0));
    chk("t3_dup_pulse_end", dup_err, 1'b0);
    beat(2'd2, cbeat(8'h80, 8'h7F));
    beat(2'd3, rbeat(9'h001, 9'h0FF, 9'h100));
    chk("t3_p_valid", p_valid, 1'b1);
    chk("t3_p_input", p_input, f1);
    handshake_frame();

    // 5b: result on the 16th cycle beats the timeout
    for (int i = 0; i < 15; i++) tick();
    chk("t5b_no_timeout_yet", timeout_err, 1'b0);
    o = 24'h123456; o_valid = 1'b1;
    tick();
    o_valid = 1'b0;
    chk("t5b_timeout_err", timeout_err, 1'b0);
    chk("t5b_res_valid", res_valid, 1'b1);
    chk("t5b_xM", xM, 12'h123);
    chk("t5b_yM", yM, 12'h456);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t5b_res_valid_done", res_valid, 1'b0);

    // 6: reset mid-collection discards the partial frame
    beat(2'd0, cbeat(8'h99, 8'h88));
    beat(2'd1, cbeat(8'h77, 8'h66));
    rst = 1'b1;
    #1;
    chk("t6_in_ready_in_rst", in_ready, 1'b0);
    tick();
    chk("t6_in_ready_rst_edge", in_ready, 1'b0);
    chk("t6_p_input", p_input, 75'h0);
    chk("t6_xM", xM, 12'h0);
    chk("t6_yM", yM, 12'h0);
    chk("t6_p_valid", p_valid, 1'b0);
    chk("t6_errs", {dup_err, timeout_err, res_valid}, 3'b000);
    rst = 1'b0;
    #1;
    beat(2'd2, cbeat(8'hC3, 8'h3C));
    beat(2'd3, rbeat(9'h0AB, 9'h1CD, 9'h0EF));
    chk("t6_partial_lost", p_valid, 1'b0);
    beat(2'd0, cbeat(8'h7E, 8'h81));
    beat(2'd1, cbeat(8'h01, 8'hFF));
    chk("t6_p_valid", p_valid, 1'b1);
    chk("t6_p_input_fresh", p_input, f6);
    handshake_frame();
    o = 24'hFFF001; o_valid = 1'b1;
    tick();
    o_valid = 1'b0;
    chk("t6_xM_res", xM, 12'hFFF);
    chk("t6_yM_res", yM, 12'h001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
